// File: rtl/multi_rinse_wash_controller.sv
// Washing-machine sequencer: soap pass, then up to MAX_RINSE rinse passes, then spin.
// Optional pause support is enabled by defining the WASH_PAUSE_EN macro.
module multi_rinse_wash_controller #(
    parameter int TIMER_W    = 8,
    parameter int WASH_TICKS = 20,
    parameter int SPIN_TICKS = 10,
    parameter int RINSE_W    = 2,
    parameter int MAX_RINSE  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               door_close,
    input  logic               start,
    input  logic               filled,
    input  logic               detergent_added,
    input  logic               drained,
    input  logic               pause,
    input  logic [RINSE_W-1:0] rinse_count,
    output logic               door_lock,
    output logic               motor_on,
    output logic               fill_valve_on,
    output logic               drain_valve_on,
    output logic               soap_wash,
    output logic               water_wash,
    output logic               done,
    output logic               fault,
    output logic [RINSE_W-1:0] rinse_left,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_DRAIN = 3'd3,
        S_SPIN  = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam logic [TIMER_W-1:0] WASH_LOAD = TIMER_W'(WASH_TICKS - 1);
    localparam logic [TIMER_W-1:0] SPIN_LOAD = TIMER_W'(SPIN_TICKS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_next;
    logic [RINSE_W-1:0] r_rinse_left;
    logic [RINSE_W-1:0] w_rinse_left_next;
    logic               r_rinse_pass;      // 0 = soap pass, 1 = rinse pass
    logic               w_rinse_pass_next;
    logic [RINSE_W-1:0] w_rinse_clamped;
    logic               w_locked;
    logic               w_paused;

    assign w_locked = (r_state == S_FILL) || (r_state == S_WASH) ||
                      (r_state == S_DRAIN) || (r_state == S_SPIN);

`ifdef WASH_PAUSE_EN
    assign w_paused = pause & w_locked;
`else
    // The pause pin stays on the boundary but never takes effect in this build.
    assign w_paused = pause & 1'b0;
`endif

    assign w_rinse_clamped = (32'(rinse_count) > MAX_RINSE) ? RINSE_W'(MAX_RINSE) : rinse_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_rinse_left <= '0;
            r_rinse_pass <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_rinse_left <= w_rinse_left_next;
            r_rinse_pass <= w_rinse_pass_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_timer_next      = r_timer;
        w_rinse_left_next = r_rinse_left;
        w_rinse_pass_next = r_rinse_pass;
        // An opened door beats every other transition, including pause.
        if (w_locked && !door_close) begin
            w_state_next = S_FAULT;
        end else if (!w_paused) begin
            case (r_state)
                S_IDLE: begin
                    if (start && door_close) begin
                        w_state_next      = S_FILL;
                        w_rinse_left_next = w_rinse_clamped;
                        w_rinse_pass_next = 1'b0;
                    end
                end
                S_FILL: begin
                    if (filled && (r_rinse_pass || detergent_added)) begin
                        w_state_next = S_WASH;
                        w_timer_next = WASH_LOAD;
                    end
                end
                S_WASH: begin
                    if (r_timer == '0) begin
                        w_state_next = S_DRAIN;
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        if (r_rinse_left != '0) begin
                            w_rinse_left_next = r_rinse_left - 1'b1;
                            w_rinse_pass_next = 1'b1;
                            w_state_next      = S_FILL;
                        end else begin
                            w_state_next = S_SPIN;
                            w_timer_next = SPIN_LOAD;
                        end
                    end
                end
                S_SPIN: begin
                    if (r_timer == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                S_DONE: begin
                    if (!door_close) begin
                        w_state_next = S_IDLE;
                    end
                end
                S_FAULT: begin
                    if (!start && door_close) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Moore outputs; a pause only silences the water/motor actuators.
    always_comb begin
        door_lock      = w_locked;
        fill_valve_on  = (r_state == S_FILL) && !w_paused;
        motor_on       = ((r_state == S_WASH) || (r_state == S_SPIN)) && !w_paused;
        drain_valve_on = ((r_state == S_DRAIN) || (r_state == S_SPIN)) && !w_paused;
        soap_wash      = (r_state == S_WASH) && !r_rinse_pass;
        water_wash     = (r_state == S_WASH) && r_rinse_pass;
        done           = (r_state == S_DONE);
        fault          = (r_state == S_FAULT);
    end

    assign rinse_left = r_rinse_left;
    assign state      = r_state;

endmodule

// File: doc/multi_rinse_wash_controller.md
MULTI_RINSE_WASH_CONTROLLER -- requirements
Module: multi_rinse_wash_controller

Interface
REQ-001 Parameter TIMER_W, default 8, width of internal phase timer.
REQ-002 Parameter WASH_TICKS, default 20, WASH phase length in clk cycles (1..2^TIMER_W).
REQ-003 Parameter SPIN_TICKS, default 10, SPIN phase length in clk cycles (1..2^TIMER_W).
REQ-004 Parameter RINSE_W, default 2, width of rinse_count/rinse_left; MAX_RINSE, default 3, upper clamp.
REQ-005 clk  in  1  single system clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 door_close, start, filled, detergent_added, drained, pause  in  1 each  machine sensors/controls, synchronous to clk.
REQ-008 rinse_count  in  RINSE_W  number of rinse passes requested, sampled at start.
REQ-009 door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash, done, fault  out  1 each  actuators/status.
REQ-010 rinse_left  out  RINSE_W  rinse passes still to run; state  out  3  current state code.

Function
REQ-011 States SHALL be IDLE=0, FILL=1, WASH=2, DRAIN=3, SPIN=4, DONE=5, FAULT=6; all outputs Moore-decoded from the state register, valid in the first cycle of the state.
REQ-012 IDLE->FILL on the edge where start=1 and door_close=1; same edge loads rinse_left=min(rinse_count,MAX_RINSE) and clears pass flag (soap pass).
REQ-013 FILL: fill_valve_on=1; exit to WASH when filled=1, and on the soap pass also detergent_added=1; rinse passes ignore detergent_added.
REQ-014 WASH: motor_on=1, soap_wash=1 on soap pass else water_wash=1; timer loads WASH_TICKS-1 on entry, decrements each cycle, exits to DRAIN on the cycle timer=0 (exactly WASH_TICKS cycles).
REQ-015 DRAIN: drain_valve_on=1; when drained=1: if rinse_left>0, decrement rinse_left, set pass flag to rinse, go to FILL; else go to SPIN.
REQ-016 SPIN: motor_on=1 and drain_valve_on=1 for exactly SPIN_TICKS cycles, then DONE.
REQ-017 door_lock=1 in FILL, WASH, DRAIN, SPIN; 0 in IDLE, DONE, FAULT.
REQ-018 DONE: done=1; stays until door_close=0, then IDLE.
REQ-019 door_close=0 in any locked state SHALL enter FAULT next edge, overriding every other transition; FAULT drives fault=1, all actuators 0; FAULT->IDLE when start=0 and door_close=1.
REQ-020 start while not IDLE SHALL be ignored; rinse_count changes after start SHALL have no effect.
REQ-021 rinse_count=0 SHALL run exactly one soap pass then SPIN; rinse_count>MAX_RINSE SHALL clamp to MAX_RINSE.
REQ-022 Simultaneous filled and drained or other sensors SHALL only be evaluated in their owning state.

Reset
REQ-023 reset_n=0 SHALL immediately force state=IDLE, timer=0, rinse_left=0, pass flag=soap, all outputs 0, independent of clk.
REQ-024 Reset mid-cycle SHALL abandon the cycle; first start after release begins a fresh soap pass.
REQ-025 Reset release SHALL be synchronous to clk at the instantiating level; block takes no action before first edge after release.

Configuration
REQ-026 Macro WASH_PAUSE_EN: when defined, pause=1 in FILL, WASH, DRAIN or SPIN SHALL freeze state and timer, force motor_on, fill_valve_on, drain_valve_on to 0, keep door_lock=1; pause=0 resumes with remaining ticks; door_close=0 still enters FAULT.
REQ-027 Without WASH_PAUSE_EN the pause port SHALL exist and be ignored.

Verification (WASH_TICKS=4, SPIN_TICKS=3, MAX_RINSE=3)
REQ-028 rinse_count=2, start+door_close, filled/detergent/drained given promptly -> states FILL,WASH(soap 4 cyc),DRAIN,FILL,WASH(water),DRAIN,FILL,WASH(water),DRAIN,SPIN(3 cyc),DONE; rinse_left 2->1->0.
REQ-029 Soap pass with filled=1, detergent_added=0 for 5 cycles -> remains FILL, fill_valve_on=1; detergent_added=1 -> WASH next edge.
REQ-030 door_close=0 during WASH cycle 2 -> FAULT next edge, fault=1, motor_on=0, door_lock=0; start=0, door_close=1 -> IDLE.
REQ-031 rinse_count=3'b... =3 with RINSE_W=2 and MAX_RINSE=1 -> rinse_left=1, exactly one rinse pass.
REQ-032 WASH_PAUSE_EN defined, pause=1 for 6 cycles after WASH cycle 1 -> motor_on=0, state=2 held, WASH then lasts 3 more active cycles; undefined -> WASH ends after 4 cycles regardless.
REQ-033 reset_n=0 asynchronously mid-SPIN -> all outputs 0 and state=0 before next clk edge.
